// File: rtl/axi_burst_ram_pkg.sv
// axi_burst_ram_pkg
//   Shared types and constants for the axi_burst_ram slice:
//   bus widths, burst/response encodings, write/read FSM state enums and
//   the AXI request (mosi) / response (miso) channel bundles.
package axi_burst_ram_pkg;

  localparam int unsigned ID_W_WIDTH     = 4;
  localparam int unsigned ID_R_WIDTH     = 4;
  localparam int unsigned ADDR_WIDTH     = 16;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned STRB_W         = AXI_DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned OFF_W          = $clog2(STRB_W);
  // One spare MSB so an INCR burst running off the top of the address space
  // still reads as out of range instead of wrapping to word 0.
  localparam int unsigned WORD_W         = ADDR_WIDTH - OFF_W + 1;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rstate_e;

  typedef struct packed {
    logic [ID_W_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]         wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      bready;
    logic [ID_R_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      rready;
  } axi_mosi_t;

  typedef struct packed {
    logic                      awready;
    logic                      wready;
    logic [ID_W_WIDTH-1:0]     bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      arready;
    logic [ID_R_WIDTH-1:0]     rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
  } axi_miso_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen
//   Per-beat word address generator for one AXI burst engine.
//   load_i latches addr/len/burst/size; each step_i advances to the next beat.
//   Ports: clk_i, rst_n_i, load_i, addr_i, len_i, burst_i, size_i, step_i,
//          word_o (RAM word index of the current beat), err_o (current beat is SLVERR).
module axi_burst_addr_gen
  import axi_burst_ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  localparam int unsigned RAM_AW     = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  input  logic [2:0]            size_i,
  input  logic                  step_i,
  output logic [RAM_AW-1:0]     word_o,
  output logic                  err_o
);

  localparam logic [WORD_W-1:0] DEPTH_LIM = WORD_W'(DEPTH_WORDS);

  logic [WORD_W-1:0] word_q, word_d;
  logic [7:0]        len_q;
  logic [1:0]        burst_q;
  logic              cfg_err_q, cfg_err_d;
  logic [WORD_W-1:0] wrap_mask;
  logic              unused_offset;

  assign unused_offset = ^addr_i[OFF_W-1:0];

  assign cfg_err_d = (size_i != 3'(OFF_W)) || (burst_i == 2'b11) ||
                     ((burst_i == BURST_WRAP) && !(len_i inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // For legal WRAP lengths len+1 is a power of two, so len itself is the wrap mask.
  assign wrap_mask = WORD_W'(len_q);

  always_comb begin
    word_d = word_q;
    case (burst_q)
      BURST_FIXED: word_d = word_q;
      BURST_WRAP:  word_d = (word_q & ~wrap_mask) | ((word_q + 1'b1) & wrap_mask);
      default:     word_d = word_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      cfg_err_q <= 1'b0;
    end else if (load_i) begin
      word_q    <= {1'b0, addr_i[ADDR_WIDTH-1:OFF_W]};
      len_q     <= len_i;
      burst_q   <= burst_i;
      cfg_err_q <= cfg_err_d;
    end else if (step_i) begin
      word_q    <= word_d;
    end
  end

  assign word_o = word_q[RAM_AW-1:0];
  assign err_o  = cfg_err_q || (word_q >= DEPTH_LIM);

endmodule

// File: rtl/axi_burst_ram_dpram.sv
// axi_burst_ram_dpram
//   Byte-enabled dual-port RAM. Port A: write with per-lane enables.
//   Port B: registered read, 1-cycle latency, read-first against port A.
//   Ports: clk_i, a_we_i, a_be_i, a_addr_i, a_wdata_i, b_re_i, b_addr_i, b_rdata_o.
module axi_burst_ram_dpram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BATCH_WIDTH = 4,
  parameter int unsigned DEPTH       = 4096,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   a_we_i,
  input  logic [BATCH_WIDTH-1:0] a_be_i,
  input  logic [AW-1:0]          a_addr_i,
  input  logic [DATA_WIDTH-1:0]  a_wdata_i,
  input  logic                   b_re_i,
  input  logic [AW-1:0]          b_addr_i,
  output logic [DATA_WIDTH-1:0]  b_rdata_o
);

  localparam int unsigned LANE_W = DATA_WIDTH / BATCH_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      for (int unsigned i = 0; i < BATCH_WIDTH; i++) begin
        if (a_be_i[i]) mem_q[a_addr_i][i*LANE_W +: LANE_W] <= a_wdata_i[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (b_re_i) b_rdata_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/axi_burst_ram.sv
// axi_burst_ram
//   AXI4 slave memory target with FIXED/INCR/WRAP bursts and SLVERR on
//   illegal size/burst or out-of-range beats. Write engine owns RAM port A,
//   read engine owns RAM port B; both run concurrently.
//   Ports: clk_i, rst_n_i (async, active-low),
//          in_mosi_i (AW, W, AR, bready, rready), in_miso_o (ready signals, B, R).
//   Build option AXI_RAM_OUT_REG_EN: extra port-B register stage (read latency 3)
//   with a 3-entry output buffer; undefined gives read latency 2 and 2 entries.
module axi_burst_ram
  import axi_burst_ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  axi_mosi_t in_mosi_i,
  output axi_miso_t in_miso_o
);

  localparam int unsigned RAM_AW = $clog2(DEPTH_WORDS);
`ifdef AXI_RAM_OUT_REG_EN
  localparam int unsigned BUF_D = 3;
`else
  localparam int unsigned BUF_D = 2;
`endif

  logic en_q;

  // ---------------- write engine ----------------
  wstate_e                 w_state_q, w_state_d;
  logic [ID_W_WIDTH-1:0]   wid_q, wid_d;
  logic [7:0]              wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic                    werr_q, werr_d;
  logic                    aw_hs, w_hs, w_err;
  logic [RAM_AW-1:0]       w_word;

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (w_state_q)
      W_IDLE: if (en_q && in_mosi_i.awvalid) begin
        aw_hs     = 1'b1;
        wid_d     = in_mosi_i.awid;
        wlen_d    = in_mosi_i.awlen;
        wcnt_d    = '0;
        werr_d    = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (in_mosi_i.wvalid) begin
        w_hs   = 1'b1;
        wcnt_d = wcnt_q + 8'd1;
        // wlast on the wrong beat (early or late) marks the burst as failed.
        werr_d = werr_q | w_err | (in_mosi_i.wlast != (wcnt_q == wlen_q));
        if (in_mosi_i.wlast) w_state_d = W_RESP;
      end
      W_RESP: if (in_mosi_i.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  axi_burst_addr_gen #(.DEPTH_WORDS(DEPTH_WORDS)) u_wr_addr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (aw_hs),
    .addr_i  (in_mosi_i.awaddr),
    .len_i   (in_mosi_i.awlen),
    .burst_i (in_mosi_i.awburst),
    .size_i  (in_mosi_i.awsize),
    .step_i  (w_hs),
    .word_o  (w_word),
    .err_o   (w_err)
  );

  // ---------------- read engine ----------------
  rstate_e                 r_state_q, r_state_d;
  logic [ID_R_WIDTH-1:0]   rid_q, rid_d;
  logic [7:0]              rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic                    rdone_q, rdone_d;
  logic                    ar_hs, issue, r_err, pop;
  logic [RAM_AW-1:0]       r_word;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;
  logic [2:0]              credit;
  logic                    s1_v_q, s1_last_q, s1_err_q;
  logic                    push_v, push_last, push_err;
  logic [AXI_DATA_WIDTH-1:0] push_data;
  // Buffer storage is 4 deep so 2-bit pointers wrap naturally; occupancy is
  // capped at BUF_D by the credit check below.
  logic [AXI_DATA_WIDTH-1:0] fdata_q [4];
  logic                    flast_q [4];
  logic                    ferr_q  [4];
  logic [1:0]              wp_q, rp_q, fcnt_q;

`ifdef AXI_RAM_OUT_REG_EN
  logic                      s2_v_q, s2_last_q, s2_err_q;
  logic [AXI_DATA_WIDTH-1:0] s2_data_q;
  assign credit    = 3'(fcnt_q) + 3'(s1_v_q) + 3'(s2_v_q);
  assign push_v    = s2_v_q;
  assign push_last = s2_last_q;
  assign push_err  = s2_err_q;
  assign push_data = s2_data_q;
`else
  assign credit    = 3'(fcnt_q) + 3'(s1_v_q);
  assign push_v    = s1_v_q;
  assign push_last = s1_last_q;
  assign push_err  = s1_err_q;
  assign push_data = ram_rdata;
`endif

  assign pop = (fcnt_q != 2'd0) && in_mosi_i.rready;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rdone_d   = rdone_q;
    ar_hs     = 1'b0;
    issue     = 1'b0;
    case (r_state_q)
      R_IDLE: if (en_q && in_mosi_i.arvalid) begin
        ar_hs     = 1'b1;
        rid_d     = in_mosi_i.arid;
        rlen_d    = in_mosi_i.arlen;
        rcnt_d    = '0;
        rdone_d   = 1'b0;
        r_state_d = R_BURST;
      end
      R_BURST: begin
        // In-flight reads count against buffer space; a pop this cycle frees a slot.
        if (!rdone_q && ((credit < 3'(BUF_D)) || pop)) begin
          issue  = 1'b1;
          rcnt_d = rcnt_q + 8'd1;
          if (rcnt_q == rlen_q) rdone_d = 1'b1;
        end
        if (rdone_q && (credit == 3'd0)) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  axi_burst_addr_gen #(.DEPTH_WORDS(DEPTH_WORDS)) u_rd_addr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (ar_hs),
    .addr_i  (in_mosi_i.araddr),
    .len_i   (in_mosi_i.arlen),
    .burst_i (in_mosi_i.arburst),
    .size_i  (in_mosi_i.arsize),
    .step_i  (issue),
    .word_o  (r_word),
    .err_o   (r_err)
  );

  axi_burst_ram_dpram #(
    .DATA_WIDTH  (AXI_DATA_WIDTH),
    .BATCH_WIDTH (STRB_W),
    .DEPTH       (DEPTH_WORDS)
  ) u_ram (
    .clk_i     (clk_i),
    .a_we_i    (w_hs && !w_err),
    .a_be_i    (in_mosi_i.wstrb),
    .a_addr_i  (w_word),
    .a_wdata_i (in_mosi_i.wdata),
    .b_re_i    (issue && !r_err),
    .b_addr_i  (r_word),
    .b_rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q      <= 1'b0;
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rdone_q   <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_err_q  <= 1'b0;
`ifdef AXI_RAM_OUT_REG_EN
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      s2_err_q  <= 1'b0;
      s2_data_q <= '0;
`endif
      wp_q      <= '0;
      rp_q      <= '0;
      fcnt_q    <= '0;
    end else begin
      en_q      <= 1'b1;
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rdone_q   <= rdone_d;
      s1_v_q    <= issue;
      s1_last_q <= (rcnt_q == rlen_q);
      s1_err_q  <= r_err;
`ifdef AXI_RAM_OUT_REG_EN
      s2_v_q    <= s1_v_q;
      s2_last_q <= s1_last_q;
      s2_err_q  <= s1_err_q;
      s2_data_q <= ram_rdata;
`endif
      if (push_v) wp_q <= wp_q + 2'd1;
      if (pop)    rp_q <= rp_q + 2'd1;
      case ({push_v, pop})
        2'b10:   fcnt_q <= fcnt_q + 2'd1;
        2'b01:   fcnt_q <= fcnt_q - 2'd1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_v) begin
      fdata_q[wp_q] <= push_err ? '0 : push_data;
      flast_q[wp_q] <= push_last;
      ferr_q[wp_q]  <= push_err;
    end
  end

  always_comb begin
    in_miso_o         = '0;
    in_miso_o.awready = en_q && (w_state_q == W_IDLE);
    in_miso_o.wready  = (w_state_q == W_DATA);
    in_miso_o.bvalid  = (w_state_q == W_RESP);
    in_miso_o.bid     = wid_q;
    in_miso_o.bresp   = ((w_state_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;
    in_miso_o.arready = en_q && (r_state_q == R_IDLE);
    in_miso_o.rid     = rid_q;
    if (fcnt_q != 2'd0) begin
      in_miso_o.rvalid = 1'b1;
      in_miso_o.rdata  = fdata_q[rp_q];
      in_miso_o.rlast  = flast_q[rp_q];
      in_miso_o.rresp  = ferr_q[rp_q] ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule
